bit_deframer: RTL and testbench
===============================

// Module: bit_deframer
// PURPOSE
//  Consumes the hard-decision bit stream (guess/write) from signal_demodulator.
//  Hunts for a sync word, resolves the BPSK 180-degree phase ambiguity from sync
//  polarity, then packs FRAME_BYTES payload bytes MSB-first onto a valid/ready
//  byte interface for the receiver back end.
// PARAMETERS
//  SYNC_WIDTH   8      sync word length in bits (2..32)
//  SYNC_WORD    8'hA5  sync pattern, MSB received first
//  FRAME_BYTES  4      payload bytes per frame after sync (1..255)
// PORTS
//  clock        in   1           system clock, all logic on posedge
//  reset_n      in   1           asynchronous active-low reset
//  bit_in       in   1           demodulated bit (demodulator guess)
//  bit_valid    in   1           1-cycle strobe, bit_in valid (demodulator write)
//  byte_out     out  8           payload byte, polarity-corrected
//  byte_valid   out  1           byte_out holds an unconsumed byte
//  byte_ready   in   1           consumer accepts byte_out when byte_valid=1
//  frame_active out  1           1 while in PAYLOAD state
//  inverted     out  1           polarity of current/last frame (1 = ~SYNC_WORD hit)
//  frame_done   out  1           1-cycle pulse after last payload byte is captured
//  overflow     out  1           sticky: payload byte dropped (output still full)
// BEHAVIOUR
//  Reset (reset_n=0, async): state=HUNT, sync shift reg=0, bit/byte counters=0,
//   byte_out=0, byte_valid=0, frame_active=0, inverted=0, frame_done=0, overflow=0.
//   Reset mid-frame abandons the frame; partial byte discarded.
//  Cycles with bit_valid=0 change no bit-path state; bits are consumed only on
//   cycles where bit_valid=1 (one bit per high cycle, back-to-back legal).
//  HUNT: on bit_valid, sr <= {sr[SYNC_WIDTH-2:0], bit_in}. Compare uses updated
//   value. If == SYNC_WORD -> PAYLOAD, inverted<=0; if == ~SYNC_WORD ->
//   PAYLOAD, inverted<=1; both registered same edge (frame_active=1 next cycle).
//   Sync detection requires SYNC_WIDTH bits since last HUNT entry (sr cleared
//   and a fill counter reset on entry); an all-zero sr never matches early.
//  PAYLOAD: on bit_valid, acc <= {acc[6:0], bit_in ^ inverted}, bit_cnt++.
//   On the 8th bit (bit_cnt==7): captured byte = {acc[6:0], bit_in^inverted};
//   bit_cnt<=0, byte_cnt++. Byte visible on byte_out with byte_valid=1 one
//   cycle after the strobe of its 8th bit.
//   After byte FRAME_BYTES captured (or dropped): frame_done=1 for one cycle,
//   state->HUNT, frame_active=0 same edge as frame_done assertion.
//  Output handshake: byte_valid stays 1, byte_out stable, until byte_ready=1
//   (transfer on that edge). byte_ready ignored when byte_valid=0.
//   Capture while byte_valid=1 and byte_ready=1 same cycle: transfer and reload,
//   byte_valid stays 1 with new byte. Capture while byte_valid=1, byte_ready=0:
//   new byte dropped, old byte kept, overflow<=1 (sticky until reset); byte
//   still counts toward FRAME_BYTES.
//  inverted holds its value after frame end until next sync hit.
//  Widths: sync counters saturate at SYNC_WIDTH; byte_cnt is 8 bits.
// TESTING
//  1 Reset with random bit_in, bit_valid=0 -> all outputs 0, no state change.
//  2 Bits A5 then DE AD BE EF, byte_ready=1 -> bytes DE,AD,BE,EF each 1 cycle
//    after its 8th strobe; inverted=0; frame_done pulse after EF; back to HUNT.
//  3 Bits 5A then 21 52 41 10 -> bytes DE,AD,BE,EF, inverted=1.
//  4 Bits 0xFF,0x00,0xA4 then A5+payload -> no false sync before the real A5.
//  5 byte_ready=0 through frame -> byte_out=DE held, overflow=1 after 2nd byte,
//    frame_done still pulses; then ready=1 -> DE transferred, byte_valid=0.
//  6 reset_n low at bit 13 of payload -> all outputs 0; new A5 frame decodes OK.

Source files
------------

// File: rtl/bit_deframer.sv
// bit_deframer
//   Takes the hard-decision bit stream from the demodulator and hunts for a
//   sync word. A match against SYNC_WORD or its complement also settles the
//   BPSK 180-degree ambiguity. The FRAME_BYTES payload bytes that follow are
//   packed MSB-first and offered on a valid/ready byte interface.
//
// Ports
//   clock         in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   bit_in        in   demodulated bit
//   bit_valid     in   one-cycle strobe qualifying bit_in
//   byte_out      out  polarity-corrected payload byte
//   byte_valid    out  byte_out holds an unconsumed byte
//   byte_ready    in   consumer takes byte_out when byte_valid is high
//   frame_active  out  high while payload bits are being collected
//   inverted      out  polarity of the current/last frame (1 = complement sync)
//   frame_done    out  one-cycle pulse after the last payload byte
//   overflow      out  sticky, a payload byte was dropped
//
// State  | meaning
// HUNT   | shifting bits in, looking for SYNC_WORD or ~SYNC_WORD
// PAYLOAD| packing FRAME_BYTES bytes, polarity-corrected by inverted
module bit_deframer #(
    parameter int                    SYNC_WIDTH  = 8,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD   = 8'hA5,
    parameter int                    FRAME_BYTES = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_active,
    output logic       inverted,
    output logic       frame_done,
    output logic       overflow
);

    localparam logic [0:0] S_HUNT    = 1'b0;
    localparam logic [0:0] S_PAYLOAD = 1'b1;

    localparam int              FW        = $clog2(SYNC_WIDTH + 1);
    localparam logic [FW-1:0]   FILL_MAX  = FW'(SYNC_WIDTH);
    localparam logic [FW-1:0]   FILL_LAST = FW'(SYNC_WIDTH - 1);
    localparam logic [7:0]      LAST_BYTE = 8'(FRAME_BYTES - 1);

    logic [0:0]            r_state;
    logic [SYNC_WIDTH-1:0] r_sr;
    logic [FW-1:0]         r_fill;
    logic [6:0]            r_acc;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_byte_cnt;
    logic [7:0]            r_byte_out;
    logic                  r_byte_valid;
    logic                  r_inverted;
    logic                  r_frame_done;
    logic                  r_overflow;

    logic [SYNC_WIDTH-1:0] w_sr_next;
    logic                  w_fill_ok;
    logic                  w_hit_pos;
    logic                  w_hit_neg;
    logic                  w_data_bit;
    logic                  w_byte_cap;
    logic [7:0]            w_new_byte;
    logic                  w_out_free;

    assign w_sr_next  = {r_sr[SYNC_WIDTH-2:0], bit_in};
    // The bit arriving now completes a full window since HUNT was entered,
    // so the cleared register can never produce an early match.
    assign w_fill_ok  = (r_fill >= FILL_LAST);
    assign w_hit_pos  = w_fill_ok && (w_sr_next == SYNC_WORD);
    assign w_hit_neg  = w_fill_ok && (w_sr_next == ~SYNC_WORD);
    assign w_data_bit = bit_in ^ r_inverted;
    assign w_byte_cap = (r_state == S_PAYLOAD) && bit_valid && (r_bit_cnt == 3'd7);
    assign w_new_byte = {r_acc, w_data_bit};
    // A byte may be loaded when the holding register is empty or is being
    // drained on this same edge.
    assign w_out_free = !r_byte_valid || byte_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_HUNT;
            r_sr         <= '0;
            r_fill       <= '0;
            r_acc        <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
            r_inverted   <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (r_byte_valid && byte_ready) begin
                r_byte_valid <= 1'b0;
            end

            if (w_byte_cap) begin
                if (w_out_free) begin
                    r_byte_out   <= w_new_byte;
                    r_byte_valid <= 1'b1;
                end else begin
                    r_overflow   <= 1'b1;
                end
            end

            if (bit_valid) begin
                case (r_state)
                    S_HUNT: begin
                        r_sr <= w_sr_next;
                        if (r_fill != FILL_MAX) begin
                            r_fill <= r_fill + FW'(1);
                        end
                        if (w_hit_pos || w_hit_neg) begin
                            r_state    <= S_PAYLOAD;
                            r_inverted <= w_hit_neg;
                            r_bit_cnt  <= '0;
                            r_byte_cnt <= '0;
                        end
                    end
                    S_PAYLOAD: begin
                        r_acc <= {r_acc[5:0], w_data_bit};
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= '0;
                            // Dropped bytes still count, so a stalled consumer
                            // cannot stretch the frame.
                            if (r_byte_cnt == LAST_BYTE) begin
                                r_byte_cnt   <= '0;
                                r_frame_done <= 1'b1;
                                r_state      <= S_HUNT;
                                r_sr         <= '0;
                                r_fill       <= '0;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 8'd1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    default: r_state <= S_HUNT;
                endcase
            end
        end
    end

    assign byte_out     = r_byte_out;
    assign byte_valid   = r_byte_valid;
    assign frame_active = (r_state == S_PAYLOAD);
    assign inverted     = r_inverted;
    assign frame_done   = r_frame_done;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_bit_deframer.sv
// tb_bit_deframer
//   Directed frames with hand-computed payloads. Expected bytes are queued as
//   stimulus is issued; a negedge monitor pops and compares on each transfer.
module tb_bit_deframer;

    logic       clock      = 1'b0;
    logic       reset_n    = 1'b0;
    logic       bit_in     = 1'b0;
    logic       bit_valid  = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_active;
    logic       inverted;
    logic       frame_done;
    logic       overflow;

    bit_deframer #(
        .SYNC_WIDTH (8),
        .SYNC_WORD  (8'hA5),
        .FRAME_BYTES(4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .frame_active(frame_active),
        .inverted    (inverted),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] data;
        logic       inv;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: a transfer happens on the next posedge whenever valid && ready
    // are both high at the negedge.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n) begin
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h, expected no transfer", byte_out);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_out", byte_out, e.data);
                    check("inverted", inverted, e.inv);
                end
            end
            if (frame_done) begin
                done_cnt++;
                check("frame_active_at_done", frame_active, 0);
            end
        end
    end

    task automatic drive_bit(input logic b);
        @(posedge clock); #1;
        bit_in    = b;
        bit_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            bit_valid = 1'b0;
            bit_in    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) drive_bit(b[i]);
    endtask

    // Sends a payload byte and checks it appears exactly one cycle after its
    // 8th strobe (consumer assumed ready and previous byte already drained).
    task automatic send_checked(input logic [7:0] b, input logic [7:0] exp_b, input string name);
        send_byte(b);
        @(negedge clock);
        check({name, "_valid_before"}, byte_valid, 0);
        @(posedge clock); #1;
        bit_valid = 1'b0;
        @(negedge clock);
        check({name, "_valid_after"}, byte_valid, 1);
        check({name, "_data"}, byte_out, exp_b);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic inv);
        exp_t e;
        e.data = d;
        e.inv  = inv;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_byte_out"},     byte_out,     0);
        check({name, "_byte_valid"},   byte_valid,   0);
        check({name, "_frame_active"}, frame_active, 0);
        check({name, "_inverted"},     inverted,     0);
        check({name, "_frame_done"},   frame_done,   0);
        check({name, "_overflow"},     overflow,     0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;

        // 1: reset with noise on bit_in, no strobes
        reset_n = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            bit_in = 1'($urandom_range(0, 1));
        end
        @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        idle(10);
        @(negedge clock);
        check_all_zero("idle_after_reset");

        // 2: normal polarity frame
        byte_ready = 1'b1;
        d0 = done_cnt;
        send_byte(8'hA5);
        idle(1);
        @(negedge clock);
        check("t2_frame_active", frame_active, 1);
        check("t2_inverted", inverted, 0);
        push_exp(8'hDE, 1'b0); send_checked(8'hDE, 8'hDE, "t2_b0");
        push_exp(8'hAD, 1'b0); send_checked(8'hAD, 8'hAD, "t2_b1");
        push_exp(8'hBE, 1'b0); send_checked(8'hBE, 8'hBE, "t2_b2");
        push_exp(8'hEF, 1'b0); send_checked(8'hEF, 8'hEF, "t2_b3");
        idle(2);
        check("t2_frame_done", done_cnt, d0 + 1);
        check("t2_back_to_hunt", frame_active, 0);

        // 3: inverted polarity, back-to-back bits
        d0 = done_cnt;
        push_exp(8'hDE, 1'b1);
        push_exp(8'hAD, 1'b1);
        push_exp(8'hBE, 1'b1);
        push_exp(8'hEF, 1'b1);
        send_byte(8'h5A);
        send_byte(8'h21);
        send_byte(8'h52);
        send_byte(8'h41);
        send_byte(8'h10);
        idle(3);
        check("t3_inverted", inverted, 1);
        check("t3_frame_done", done_cnt, d0 + 1);

        // 4: no false sync in FF 00 A4
        send_byte(8'hFF); idle(1); @(negedge clock); check("t4_no_sync_ff", frame_active, 0);
        send_byte(8'h00); idle(1); @(negedge clock); check("t4_no_sync_00", frame_active, 0);
        send_byte(8'hA4); idle(1); @(negedge clock); check("t4_no_sync_a4", frame_active, 0);
        d0 = done_cnt;
        push_exp(8'h12, 1'b0);
        push_exp(8'h34, 1'b0);
        push_exp(8'h56, 1'b0);
        push_exp(8'h78, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        idle(3);
        check("t4_inverted", inverted, 0);
        check("t4_frame_done", done_cnt, d0 + 1);
        check("t4_overflow", overflow, 0);

        // 5: consumer stalled for the whole frame
        byte_ready = 1'b0;
        d0 = done_cnt;
        push_exp(8'hDE, 1'b0);
        send_byte(8'hA5);
        send_byte(8'hDE);
        idle(1);
        @(negedge clock);
        check("t5_b0_valid", byte_valid, 1);
        check("t5_b0_data", byte_out, 8'hDE);
        check("t5_no_ovf_yet", overflow, 0);
        send_byte(8'hAD);
        idle(1);
        @(negedge clock);
        check("t5_ovf_after_b1", overflow, 1);
        check("t5_held_data", byte_out, 8'hDE);
        send_byte(8'hBE);
        send_byte(8'hEF);
        idle(2);
        check("t5_frame_done", done_cnt, d0 + 1);
        check("t5_held_valid", byte_valid, 1);
        @(posedge clock); #1;
        byte_ready = 1'b1;
        @(negedge clock);
        @(posedge clock); #1;
        @(negedge clock);
        check("t5_drained", byte_valid, 0);
        check("t5_ovf_sticky", overflow, 1);

        // 6: reset at payload bit 13, then a clean frame
        push_exp(8'hDE, 1'b0);
        send_byte(8'hA5);
        send_checked(8'hDE, 8'hDE, "t6_b0");
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        drive_bit(1'b0); drive_bit(1'b1);
        @(posedge clock); #1;
        bit_valid = 1'b0;
        check("t6_active_pre_reset", frame_active, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        idle(2);
        reset_n = 1'b1;
        idle(1);
        d0 = done_cnt;
        push_exp(8'hDE, 1'b0);
        push_exp(8'hAD, 1'b0);
        push_exp(8'hBE, 1'b0);
        push_exp(8'hEF, 1'b0);
        send_byte(8'hA5);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_byte(8'hEF);
        idle(3);
        check("t6_frame_done", done_cnt, d0 + 1);
        check("t6_overflow", overflow, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
